// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, multi-cycle MUL hold
// in EX, and younger-stage flush on a taken branch resolved in MEM. Outputs are Mealy.
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_ra,
    input  logic [4:0]       id_rb,
    input  logic             id_uses_rb,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rw,
    input  logic             ex_mul,
    input  logic             mem_br_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             mul_done,
    output logic             state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // The down-counter must hold MUL_CYCLES-2, loaded on MUL cycle 1.
    localparam int MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
    localparam logic [MC_W-1:0] MUL_LOAD = (MUL_CYCLES > 2) ? MC_W'(MUL_CYCLES - 2) : '0;
    localparam logic [4:0]      XZR      = 5'd31;

    state_t            state_q, state_d;
    logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              load_use;

    assign load_use = ex_mem_read && (ex_rw != XZR) &&
                      ((ex_rw == id_ra) || (id_uses_rb && (ex_rw == id_rb)));

    // NOTE: every output and next-state value gets a default before any branch so that
    // no path through this block leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        idex_write_en = 1'b1;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        flush_exmem   = 1'b0;
        mul_done      = 1'b0;

        // Outputs are forced idle for as long as reset is held, whatever the inputs show.
        if (!reset) begin
            if (mem_br_taken) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
                state_d     = RUN;
                mul_cnt_d   = '0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (ex_mul) begin
                            if (MUL_CYCLES > 1) begin
                                pc_write_en   = 1'b0;
                                ifid_write_en = 1'b0;
                                idex_write_en = 1'b0;
                                exmem_bubble  = 1'b1;
                                mul_cnt_d     = MUL_LOAD;
                                state_d       = MUL_BUSY;
                            end else begin
                                mul_done = 1'b1;
                            end
                        end else if (load_use) begin
                            pc_write_en   = 1'b0;
                            ifid_write_en = 1'b0;
                            idex_bubble   = 1'b1;
                        end
                    end
                    MUL_BUSY: begin
                        if (mul_cnt_q != '0) begin
                            pc_write_en   = 1'b0;
                            ifid_write_en = 1'b0;
                            idex_write_en = 1'b0;
                            exmem_bubble  = 1'b1;
                            mul_cnt_d     = mul_cnt_q - 1'b1;
                        end else begin
                            mul_done = 1'b1;
                            state_d  = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end

        stall_d = stall_q;
        if (!pc_write_en && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        flush_d = flush_q;
        if (flush_exmem && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance (MUL_CYCLES=4) and a small
// instance (MUL_CYCLES=1, CNT_W=2) share stimulus; expectations go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_ra, id_rb, ex_rw;
    logic       id_uses_rb, ex_mem_read, ex_mul, mem_br_taken;

    logic        pc_we, ifid_we, idex_we, idex_bub, exmem_bub, fl_ifid, fl_idex, fl_exmem, mdone, st;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_we, s_ifid_we, s_idex_we, s_idex_bub, s_exmem_bub;
    logic        s_fl_ifid, s_fl_idex, s_fl_exmem, s_mdone, s_st;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    // Output vector order: {pc, ifid, idex, idex_bubble, exmem_bubble, fl_ifid, fl_idex, fl_exmem, mul_done, state}
    localparam logic [9:0] IDLE  = 10'b1110000000;
    localparam logic [9:0] LU    = 10'b0011000000;
    localparam logic [9:0] HOLD0 = 10'b0000100000;
    localparam logic [9:0] HOLD1 = 10'b0000100001;
    localparam logic [9:0] DONE1 = 10'b1110000011;
    localparam logic [9:0] DONE0 = 10'b1110000010;
    localparam logic [9:0] FL0   = 10'b1110011100;
    localparam logic [9:0] FL1   = 10'b1110011101;

    typedef struct {
        string      tag;
        logic [9:0] out;
        int         stall;
        int         flush;
        logic [9:0] s_out;
        int         s_stall;
        int         s_flush;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_ra(id_ra), .id_rb(id_rb), .id_uses_rb(id_uses_rb),
        .ex_mem_read(ex_mem_read), .ex_rw(ex_rw), .ex_mul(ex_mul), .mem_br_taken(mem_br_taken),
        .pc_write_en(pc_we), .ifid_write_en(ifid_we), .idex_write_en(idex_we),
        .idex_bubble(idex_bub), .exmem_bubble(exmem_bub),
        .flush_ifid(fl_ifid), .flush_idex(fl_idex), .flush_exmem(fl_exmem),
        .mul_done(mdone), .state(st), .stall_cycles(stall_cnt), .flush_events(flush_cnt)
    );

    pipeline_hazard_ctrl #(.MUL_CYCLES(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .id_ra(id_ra), .id_rb(id_rb), .id_uses_rb(id_uses_rb),
        .ex_mem_read(ex_mem_read), .ex_rw(ex_rw), .ex_mul(ex_mul), .mem_br_taken(mem_br_taken),
        .pc_write_en(s_pc_we), .ifid_write_en(s_ifid_we), .idex_write_en(s_idex_we),
        .idex_bubble(s_idex_bub), .exmem_bubble(s_exmem_bub),
        .flush_ifid(s_fl_ifid), .flush_idex(s_fl_idex), .flush_exmem(s_fl_exmem),
        .mul_done(s_mdone), .state(s_st), .stall_cycles(s_stall_cnt), .flush_events(s_flush_cnt)
    );

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic urb,
                         input logic mr, input logic [4:0] rw, input logic mul, input logic br);
        id_ra = ra; id_rb = rb; id_uses_rb = urb;
        ex_mem_read = mr; ex_rw = rw; ex_mul = mul; mem_br_taken = br;
    endtask

    task automatic push_exp(input string tag, input logic [9:0] eo, input int es, input int ef,
                            input logic [9:0] so, input int ss, input int sf);
        exp_t e;
        e.tag = tag; e.out = eo; e.stall = es; e.flush = ef;
        e.s_out = so; e.s_stall = ss; e.s_flush = sf;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t       e;
        logic [9:0] obs, s_obs;
        n_asserts++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got size %0d expected >0", sb.size());
        end
        if (sb.size() != 0) begin
            e     = sb.pop_front();
            obs   = {pc_we, ifid_we, idex_we, idex_bub, exmem_bub, fl_ifid, fl_idex, fl_exmem, mdone, st};
            s_obs = {s_pc_we, s_ifid_we, s_idex_we, s_idex_bub, s_exmem_bub,
                     s_fl_ifid, s_fl_idex, s_fl_exmem, s_mdone, s_st};
            n_asserts++;
            assert (obs === e.out) else begin
                n_fail++;
                $error("FAIL %s outputs: got %b expected %b", e.tag, obs, e.out);
            end
            n_asserts++;
            assert (stall_cnt === 32'(e.stall)) else begin
                n_fail++;
                $error("FAIL %s stall_cycles: got %0d expected %0d", e.tag, stall_cnt, e.stall);
            end
            n_asserts++;
            assert (flush_cnt === 32'(e.flush)) else begin
                n_fail++;
                $error("FAIL %s flush_events: got %0d expected %0d", e.tag, flush_cnt, e.flush);
            end
            n_asserts++;
            assert (s_obs === e.s_out) else begin
                n_fail++;
                $error("FAIL %s small outputs: got %b expected %b", e.tag, s_obs, e.s_out);
            end
            n_asserts++;
            assert (s_stall_cnt === 2'(e.s_stall)) else begin
                n_fail++;
                $error("FAIL %s small stall_cycles: got %0d expected %0d", e.tag, s_stall_cnt, e.s_stall);
            end
            n_asserts++;
            assert (s_flush_cnt === 2'(e.s_flush)) else begin
                n_fail++;
                $error("FAIL %s small flush_events: got %0d expected %0d", e.tag, s_flush_cnt, e.s_flush);
            end
        end
    endtask

    // One cycle: drive after the falling edge, compare 2 time units later, before the rising edge.
    task automatic step(input string tag,
                        input logic [4:0] ra, input logic [4:0] rb, input logic urb,
                        input logic mr, input logic [4:0] rw, input logic mul, input logic br,
                        input logic [9:0] eo, input int es, input int ef,
                        input logic [9:0] so, input int ss, input int sf);
        @(negedge clk);
        drive(ra, rb, urb, mr, rw, mul, br);
        push_exp(tag, eo, es, ef, so, ss, sf);
        #2;
        check_head();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        step("in_reset",    1, 2, 1, 0,  3, 0, 0, IDLE, 0, 0, IDLE, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        //            tag           ra  rb urb mr  rw mul br  main          small
        step("idle",          1,  2, 1, 0,  3, 0, 0, IDLE,  0, 0, IDLE,  0, 0);
        step("lu_ra",         1,  2, 1, 1,  1, 0, 0, LU,    0, 0, LU,    0, 0);
        step("after_lu",      1,  2, 1, 0,  3, 0, 0, IDLE,  1, 0, IDLE,  1, 0);
        step("xzr",          31, 31, 1, 1, 31, 0, 0, IDLE,  1, 0, IDLE,  1, 0);
        step("rb_unused",     1,  5, 0, 1,  5, 0, 0, IDLE,  1, 0, IDLE,  1, 0);
        step("lu_rb",         1,  5, 1, 1,  5, 0, 0, LU,    1, 0, LU,    1, 0);
        step("mul_c1",        1,  2, 1, 0,  3, 1, 0, HOLD0, 2, 0, DONE0, 2, 0);
        step("mul_c2",        1,  2, 1, 0,  3, 1, 0, HOLD1, 3, 0, DONE0, 2, 0);
        step("mul_c3",        1,  2, 1, 0,  3, 1, 0, HOLD1, 4, 0, DONE0, 2, 0);
        step("mul_c4",        1,  2, 1, 0,  3, 1, 0, DONE1, 5, 0, DONE0, 2, 0);
        step("mul_exit",      1,  2, 1, 0,  3, 0, 0, IDLE,  5, 0, IDLE,  2, 0);
        step("mulbr_c1",      1,  2, 1, 0,  3, 1, 0, HOLD0, 5, 0, DONE0, 2, 0);
        step("mulbr_c2",      1,  2, 1, 0,  3, 1, 1, FL1,   6, 0, FL0,   2, 0);
        step("mulbr_after",   1,  2, 1, 0,  3, 0, 0, IDLE,  6, 1, IDLE,  2, 1);
        step("br_lu",         3,  2, 1, 1,  3, 0, 1, FL0,   6, 1, FL0,   2, 1);
        step("br_lu_after",   1,  2, 1, 0,  3, 0, 0, IDLE,  6, 2, IDLE,  2, 2);
        step("mulrst_c1",     1,  2, 1, 0,  3, 1, 0, HOLD0, 6, 2, DONE0, 2, 2);
        step("mulrst_c2",     1,  2, 1, 0,  3, 1, 0, HOLD1, 7, 2, DONE0, 2, 2);

        // Asynchronous reset between edges while ex_mul is still high.
        #1 reset = 1'b1;
        push_exp("async_rst", IDLE, 0, 0, IDLE, 0, 0);
        #1 check_head();
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step("post_rst",      1,  2, 1, 0,  3, 0, 0, IDLE,  0, 0, IDLE,  0, 0);
        for (int i = 0; i < 5; i++) begin
            step("lu_sat",    2,  2, 1, 1,  2, 0, 0, LU,    i, 0, LU,    (i > 3) ? 3 : i, 0);
        end
        step("lu_sat_end",    1,  2, 1, 0,  3, 0, 0, IDLE,  5, 0, IDLE,  3, 0);
        for (int i = 0; i < 5; i++) begin
            step("br_sat",    1,  2, 1, 0,  3, 0, 1, FL0,   5, i, FL0,   3, (i > 3) ? 3 : i);
        end
        step("br_sat_end",    1,  2, 1, 0,  3, 0, 0, IDLE,  5, 5, IDLE,  3, 3);

        n_asserts++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
